// File: rtl/lsu_master_if.sv
// lsu_master_if: req/ack data-memory bus between the load/store initiator and its responder.
interface lsu_master_if;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_master.sv
// lsu_master: load/store initiator with writeback result and range checking.
// Define LSU_TIMEOUT_EN to abandon a request after TIMEOUT_CYCLES without ack.
module lsu_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [5:0]   op,
    input  logic [31:0]  alu_i,
    input  logic [31:0]  addr_i,
    lsu_master_if.master bus,
    output logic [31:0]  write_o,
    output logic         done,
    output logic         busy,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic        done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d, write_q, write_d;
    logic        is_alu, is_jmp, is_mem, timeout;
    assign is_alu = op <= 6'd5;
    assign is_jmp = op[5:1] == 5'b10000;
    assign is_mem = op[5:1] == 5'b01000;
`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // An ack in the limit cycle takes priority over the timeout.
    assign timeout = !bus.mem_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign cnt_d   = (state_q == REQ && !bus.mem_ack) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        write_d     = write_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                err_d = 1'b0;
                if (is_mem && addr_i[31:8] == 24'd0) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = !op[0];
                    mem_addr_d  = addr_i[7:0];
                    mem_wdata_d = alu_i;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = is_mem;
                    write_d = is_alu ? alu_i : is_jmp ? addr_i : write_q;
                end
            end
            REQ: if (bus.mem_ack || timeout) begin
                state_d   = FIN;
                done_d    = 1'b1;
                mem_req_d = 1'b0;
                err_d     = !bus.mem_ack;
                write_d   = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : write_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            write_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            write_q     <= write_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign write_o       = write_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed stimulus with a done-driven scoreboard and a behavioural memory responder.
module tb_lsu_master;
    logic        clk = 1'b0, rst_n = 1'b0, go = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] alu_i = '0, addr_i = '0, write_o;
    logic        done, busy, err;
    logic        rsp_ack = 1'b0, stray_ack = 1'b0, rsp_en = 1'b1;
    logic [31:0] rdata = '0;
    logic [31:0] mem_model [256];
    int          ack_delay = 0, wait_cnt = 0, req_cycles = 0, hold_bad = 0;
    logic [7:0]  a0;
    logic        we0;
    logic [31:0] d0;
    int          n_checks = 0, n_fail = 0, n_go = 0, done_cnt = 0;
    logic        prev_done = 1'b0;
    typedef struct {logic [31:0] w; logic e;} exp_t;
    exp_t        exp_q [$];

    localparam logic [5:0] OP_SW = 6'b010000, OP_LW = 6'b010001;

    lsu_master_if bus();
    assign bus.mem_ack   = rsp_ack | stray_ack;
    assign bus.mem_rdata = rdata;

    lsu_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .op(op), .alu_i(alu_i), .addr_i(addr_i),
        .bus(bus), .write_o(write_o), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: acks ack_delay cycles after mem_req first seen; also tracks request stability.
    always @(negedge clk) begin
        rsp_ack = 1'b0;
        if (bus.mem_req) begin
            req_cycles++;
            if (wait_cnt == 0) begin
                a0 = bus.mem_addr; we0 = bus.mem_we; d0 = bus.mem_wdata;
            end else if ({bus.mem_addr, bus.mem_we, bus.mem_wdata} != {a0, we0, d0}) hold_bad++;
            if (rsp_en && wait_cnt >= ack_delay) begin
                rsp_ack = 1'b1;
                rdata = mem_model[bus.mem_addr];
                if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
                wait_cnt = 0;
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    // Monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_write_o", write_o, e.w);
                check("sb_err", 32'(err), 32'(e.e));
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] ad,
                         input bit push, input logic [31:0] ew, input logic ee);
        @(negedge clk);
        go = 1'b1; op = o; alu_i = a; addr_i = ad;
        req_cycles = 0; hold_bad = 0;
        if (push) begin
            exp_q.push_back('{w: ew, e: ee});
            n_go++;
        end
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done_within_bound", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {done, err, bus.mem_we}, 32'd0);
        check("rst_write_o", write_o, 32'd0);
        check("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata[23:0]}, 32'd0);
        rst_n = 1'b1;

        issue(6'b000011, 32'h0000_1234, 32'h0, 1, 32'h0000_1234, 0);
        check("alu_done_latency", 32'(done), 32'd1);
        check("alu_write_o", write_o, 32'h0000_1234);
        wait_done(5);
        @(negedge clk);
        check("alu_busy_idle", 32'(busy), 32'd0);
        check("alu_no_req", 32'(req_cycles), 32'd0);

        ack_delay = 2;
        issue(OP_SW, 32'hDEAD_BEEF, 32'h05, 1, 32'h0000_1234, 0);
        check("sw_req_rise", 32'(bus.mem_req), 32'd1);
        wait_done(20);
        check("sw_req_cycles", 32'(req_cycles), 32'd3);
        check("sw_hold", 32'(hold_bad), 32'd0);
        check("sw_addr", 32'(a0), 32'h05);
        check("sw_we", 32'(we0), 32'd1);
        check("sw_wdata", d0, 32'hDEAD_BEEF);
        check("sw_req_low_at_done", 32'(bus.mem_req), 32'd0);

        ack_delay = 0;
        issue(OP_LW, 32'h0, 32'h05, 1, 32'hDEAD_BEEF, 0);
        wait_done(20);
        check("lw_req_cycles", 32'(req_cycles), 32'd1);
        check("lw_we", 32'(we0), 32'd0);

        issue(6'b100001, 32'h5555_5555, 32'h0ABC_0000, 1, 32'h0ABC_0000, 0);
        wait_done(5);
        issue(6'b111111, 32'h7777_7777, 32'h0000_0011, 1, 32'h0ABC_0000, 0);
        wait_done(5);

        issue(OP_LW, 32'h0, 32'h0000_0100, 1, 32'h0ABC_0000, 1);
        check("oor_done_latency", 32'(done), 32'd1);
        check("oor_err", 32'(err), 32'd1);
        check("oor_no_req", 32'(req_cycles), 32'd0);
        issue(6'b000000, 32'h0000_0042, 32'h0, 1, 32'h0000_0042, 0);
        check("err_cleared", 32'(err), 32'd0);
        wait_done(5);

        ack_delay = 3;
        issue(OP_SW, 32'h0000_1111, 32'h07, 1, 32'h0000_0042, 0);
        go = 1'b1; op = 6'b000011; alu_i = 32'h0000_9999;
        repeat (2) @(negedge clk);
        go = 1'b0;
        wait_done(20);
        check("busy_req_cycles", 32'(req_cycles), 32'd4);
        @(negedge clk);
        check("busy_no_queue", {busy, done}, 32'd0);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_ack_ignored", {busy, done, bus.mem_req}, 32'd0);
        @(negedge clk);
        check("stray_ack_no_done", 32'(done), 32'd0);

        ack_delay = 1;
        issue(OP_LW, 32'h0, 32'h07, 1, 32'h0000_1111, 0);
        wait_done(20);

        rsp_en = 1'b0;
        issue(OP_LW, 32'h0, 32'h05, 0, 32'h0, 0);
        @(negedge clk);
        check("pre_reset_req", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(bus.mem_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_write_o", write_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_en = 1'b1;
        ack_delay = 0;
        issue(OP_LW, 32'h0, 32'h05, 1, 32'hDEAD_BEEF, 0);
        wait_done(20);

`ifdef LSU_TIMEOUT_EN
        rsp_en = 1'b0;
        issue(OP_LW, 32'h0, 32'h05, 1, 32'hDEAD_BEEF, 1);
        wait_done(20);
        check("to_req_cycles", 32'(req_cycles), 32'd4);
        rsp_en = 1'b1;
        ack_delay = 3;
        issue(OP_LW, 32'h0, 32'h07, 1, 32'h0000_1111, 0);
        wait_done(20);
        check("to_edge_req_cycles", 32'(req_cycles), 32'd4);
`endif

        repeat (3) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(n_go));
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store initiator between the execute stage and data memory. It takes one decoded operation per `go` pulse, drives a req/ack handshake to a single-port 256-word data memory, and returns the writeback value with a one-cycle `done` pulse. It replaces the phase-strobed direct memory array access: the memory becomes a handshaked responder with variable latency, and this block owns sequencing, range checking and the writeback result.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles `mem_req` may wait for `mem_ack` (only with `LSU_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: start pulse from phase controller; sampled only in IDLE.
- `op` in 6: operation code, sampled with `go`.
- `alu_i` in 32: ALU result / store data, sampled with `go`.
- `addr_i` in 32: word address or pass-through value, sampled with `go`.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store, 0 = load; valid while `mem_req`.
- `mem_addr` out 8: word address, `addr_i[7:0]`.
- `mem_wdata` out 32: store data.
- `mem_ack` in 1: responder completion; one-cycle pulse.
- `mem_rdata` in 32: load data, valid in the `mem_ack` cycle.
- `write_o` out 32: writeback value, held until next update.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky error flag, cleared by the next accepted `go`.

## Operation
- States: IDLE, REQ, FIN.
- IDLE + `go`: latch `op`, `alu_i` and `addr_i`, clear `err`, then dispatch:
  - `op` 000000–000101 (ALU): `write_o <= alu_i`; go to FIN.
  - `op` 100000, 100001 (jump/link): `write_o <= addr_i`; go to FIN.
  - `op` 010000 (SW) or 010001 (LW), `addr_i[31:8]==0`: go to REQ with `mem_we` = 1 for SW, 0 for LW.
  - SW/LW with `addr_i[31:8]!=0`: no request; set `err`; go to FIN; `write_o` unchanged.
  - Any other `op`: no action; go to FIN; `write_o` unchanged.
- REQ: `mem_req`=1; `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ack`.
  - On `mem_ack`: LW sets `write_o <= mem_rdata`; SW leaves `write_o` unchanged; go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- `go` outside IDLE is ignored, with no queuing.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values: `mem_req`, `mem_we`, `done`, `busy`, `err` = 0; `mem_addr` = 0; `mem_wdata` = 0; `write_o` = 0; state IDLE.
- Reset applies immediately when asserted. `mem_req` drops asynchronously, even mid-handshake, and the transaction is abandoned.
- Non-memory op: `go` in cycle 0 → `write_o` valid and `done` in cycle 1 → IDLE in cycle 2.
- Memory op: `go` in cycle 0 → `mem_req` rises in cycle 1.
  - `mem_ack` in cycle k (k ≥ 1, same cycle as `mem_req` allowed) → `mem_req` low and `done` high in cycle k+1.
  - LW: `write_o` is updated in cycle k+1.
- Earliest back-to-back `go` is accepted one cycle after `done`.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter starts at 0 on entry to REQ and increments each cycle `mem_ack` is low.
  - When it reaches `TIMEOUT_CYCLES` with no ack: `mem_req` drops, `err` = 1, go to FIN, `write_o` unchanged.
  - An ack in the same cycle as the count limit wins.
- `LSU_TIMEOUT_EN` undefined: no counter; REQ waits for `mem_ack` indefinitely.

## Test plan
- ALU pass-through: `go`, `op`=000011, `alu_i`=0x0000_1234 → `write_o`=0x1234 and `done` exactly 1 cycle later; `mem_req` never asserts.
- Store then load:
  - SW with `addr_i`=0x05, `alu_i`=0xDEAD_BEEF; responder acks after 3 cycles → `mem_we`=1, `mem_addr`=0x05 held 3 cycles; `done`; `write_o` unchanged.
  - Then LW to 0x05 → `write_o`=0xDEAD_BEEF.
- Out-of-range: LW with `addr_i`=0x0000_0100 → no `mem_req`; `done` 1 cycle later with `err`=1; the next valid `go` clears `err`.
- Busy and stray signals: `go` pulses during REQ and a stray `mem_ack` in IDLE → both ignored; exactly one `done` per accepted `go`.
- Reset mid-REQ: deassert `rst_n` while `mem_req`=1 → `mem_req`, `busy` and `write_o` go to 0 immediately; after release the state is IDLE and the next LW completes normally.
- Timeout (`LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4): LW with no ack → `mem_req` high for 4 cycles, then `err`=1 and `done`.
  - Ack exactly in the 4th cycle → normal completion with `err`=0.
